// File: rtl/row_addr_cam_multi.sv
// -----------------------------------------------------------------------------
// row_addr_cam_multi
//
// Row-address CAM with N_ENTRY entries and per-entry valid bits. A search
// walks the table LANES entries per cycle, lowest index first, and stops at
// the first chunk that holds a match. Writes, invalidates and clear-all are
// single-cycle operations that never leave IDLE. On a hit, resp_idx_o selects
// the per-row counter entry downstream.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_valid_i/ready_o request handshake (ready only while IDLE)
//   req_op_i            0=SEARCH 1=WRITE 2=INVALIDATE 3=CLEAR_ALL
//   row_addr_i          search key / write data
//   idx_i               target entry for WRITE / INVALIDATE
//   resp_valid_o        one-cycle response pulse
//   resp_hit_o          search hit
//   resp_idx_o          hit index, idx_i echo for WRITE/INVALIDATE, else 0
//
// Optional feature (macro ROW_CAM_FREE_IDX_EN):
//   resp_free_vld_o     a free (invalid) entry exists, reported on search miss
//   resp_free_idx_o     lowest free entry index
// -----------------------------------------------------------------------------
module row_addr_cam_multi #(
  parameter  int ADDR_W  = 16,
  parameter  int N_ENTRY = 16,
  parameter  int LANES   = 4,
  localparam int IDX_W   = $clog2(N_ENTRY)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [ADDR_W-1:0] row_addr_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic              resp_valid_o,
  output logic              resp_hit_o,
  output logic [IDX_W-1:0]  resp_idx_o
`ifdef ROW_CAM_FREE_IDX_EN
  ,
  output logic              resp_free_vld_o,
  output logic [IDX_W-1:0]  resp_free_idx_o
`endif
);

  localparam int N_CHUNK = (N_ENTRY + LANES - 1) / LANES;
  localparam int CW      = $clog2(N_CHUNK) + 1;
  localparam int NPAD    = N_CHUNK * LANES;

  localparam logic [1:0] OP_SEARCH = 2'd0;
  localparam logic [1:0] OP_WRITE  = 2'd1;
  localparam logic [1:0] OP_INVAL  = 2'd2;
  localparam logic [1:0] OP_CLEAR  = 2'd3;

  typedef enum logic {ST_IDLE, ST_SEARCH} state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [N_ENTRY-1:0]  r_valid;
  logic [ADDR_W-1:0]   r_data [N_ENTRY];
  logic [ADDR_W-1:0]   r_key;
  logic [CW-1:0]       r_chunk;

  logic                w_accept;
  logic                w_idx_in_range;
  logic                w_last;
  logic [NPAD-1:0]     w_valid_pad;
  logic [ADDR_W-1:0]   w_data_pad [NPAD];
  logic                w_hit;
  logic [IDX_W-1:0]    w_hit_idx;

  logic                w_rv_nxt;
  logic                w_hit_nxt;
  logic [IDX_W-1:0]    w_idx_nxt;

  assign req_ready_o    = (r_state == ST_IDLE);
  assign w_accept       = req_valid_i && req_ready_o;
  assign w_idx_in_range = ({1'b0, idx_i} < (IDX_W+1)'(N_ENTRY));
  assign w_last         = (r_chunk == CW'(N_CHUNK - 1));

  // Pad the table up to a whole number of chunks; pad slots are never valid,
  // which masks the unused lanes of a partial final chunk.
  for (genvar g = 0; g < NPAD; g++) begin : g_pad
    if (g < N_ENTRY) begin : g_real
      assign w_valid_pad[g] = r_valid[g];
      assign w_data_pad[g]  = r_data[g];
    end else begin : g_mask
      assign w_valid_pad[g] = 1'b0;
      assign w_data_pad[g]  = '0;
    end
  end

  // Compare the current chunk. Lanes are scanned from high to low so the
  // lowest matching index is the last one written.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int c = 0; c < N_CHUNK; c++) begin
      for (int l = LANES - 1; l >= 0; l--) begin
        if ((r_chunk == CW'(c)) && w_valid_pad[c*LANES+l] &&
            (w_data_pad[c*LANES+l] == r_key)) begin
          w_hit     = 1'b1;
          w_hit_idx = IDX_W'(c*LANES + l);
        end
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept && (req_op_i == OP_SEARCH)) w_state_nxt = ST_SEARCH;
      ST_SEARCH: if (w_hit || w_last)                      w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM: next values of the registered response
  always_comb begin
    w_rv_nxt  = 1'b0;
    w_hit_nxt = 1'b0;
    w_idx_nxt = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (req_op_i != OP_SEARCH)) begin
          w_rv_nxt = 1'b1;
          if ((req_op_i == OP_WRITE) || (req_op_i == OP_INVAL)) w_idx_nxt = idx_i;
        end
      end
      ST_SEARCH: begin
        if (w_hit) begin
          w_rv_nxt  = 1'b1;
          w_hit_nxt = 1'b1;
          w_idx_nxt = w_hit_idx;
        end else if (w_last) begin
          w_rv_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_valid_o <= 1'b0;
      resp_hit_o   <= 1'b0;
      resp_idx_o   <= '0;
    end else begin
      resp_valid_o <= w_rv_nxt;
      resp_hit_o   <= w_hit_nxt;
      resp_idx_o   <= w_idx_nxt;
    end
  end

  // Chunk counter restarts on every accepted request and stops at the
  // last chunk, so it never wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_chunk <= '0;
    end else if (w_accept) begin
      r_chunk <= '0;
    end else if ((r_state == ST_SEARCH) && !w_hit && !w_last) begin
      r_chunk <= r_chunk + CW'(1);
    end
  end

  // Valid bits; an out-of-range index is acknowledged but changes nothing.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
    end else if (w_accept) begin
      case (req_op_i)
        OP_WRITE: if (w_idx_in_range) r_valid[idx_i] <= 1'b1;
        OP_INVAL: if (w_idx_in_range) r_valid[idx_i] <= 1'b0;
        OP_CLEAR: r_valid <= '0;
        default:  ;
      endcase
    end
  end

  // Entry data and search key carry no reset; validity lives in r_valid.
  always_ff @(posedge clk_i) begin
    if (w_accept) r_key <= row_addr_i;
    if (w_accept && (req_op_i == OP_WRITE) && w_idx_in_range) r_data[idx_i] <= row_addr_i;
  end

`ifdef ROW_CAM_FREE_IDX_EN
  logic             w_free_any;
  logic [IDX_W-1:0] w_free_idx;
  logic             r_free_found;
  logic [IDX_W-1:0] r_free_idx;

  // Lowest invalid real entry in the current chunk; pad slots are excluded.
  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int c = 0; c < N_CHUNK; c++) begin
      for (int l = LANES - 1; l >= 0; l--) begin
        if (((c*LANES + l) < N_ENTRY) && (r_chunk == CW'(c)) &&
            !w_valid_pad[c*LANES+l]) begin
          w_free_any = 1'b1;
          w_free_idx = IDX_W'(c*LANES + l);
        end
      end
    end
  end

  // Earlier chunks hold lower indices, so the first free slot seen is kept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_free_found <= 1'b0;
    end else if (w_accept) begin
      r_free_found <= 1'b0;
    end else if ((r_state == ST_SEARCH) && !r_free_found && w_free_any) begin
      r_free_found <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if ((r_state == ST_SEARCH) && !r_free_found && w_free_any) r_free_idx <= w_free_idx;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_free_vld_o <= 1'b0;
      resp_free_idx_o <= '0;
    end else if ((r_state == ST_SEARCH) && !w_hit && w_last) begin
      resp_free_vld_o <= r_free_found || w_free_any;
      resp_free_idx_o <= r_free_found ? r_free_idx : (w_free_any ? w_free_idx : '0);
    end else begin
      resp_free_vld_o <= 1'b0;
      resp_free_idx_o <= '0;
    end
  end
`else
  // Free-slot reporting not built: no extra state or outputs.
`endif

endmodule

// File: tb/tb_row_addr_cam_multi.sv
module tb_row_addr_cam_multi;

  localparam int AW = 16;
  localparam int IW = 4;
  localparam int L  = 4;

  localparam logic [1:0] OP_S = 2'd0;
  localparam logic [1:0] OP_W = 2'd1;
  localparam logic [1:0] OP_I = 2'd2;
  localparam logic [1:0] OP_C = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst     [2];
  logic          rv_in   [2];
  logic [1:0]    op_in   [2];
  logic [AW-1:0] addr_in [2];
  logic [IW-1:0] idx_in  [2];
  logic          rdy     [2];
  logic          rsp_v   [2];
  logic          rsp_h   [2];
  logic [IW-1:0] rsp_i   [2];
`ifdef ROW_CAM_FREE_IDX_EN
  logic          fv      [2];
  logic [IW-1:0] fi      [2];
`endif

  row_addr_cam_multi #(.ADDR_W(AW), .N_ENTRY(16), .LANES(L)) u_a (
    .clk_i(clk), .rst_i(rst[0]), .req_valid_i(rv_in[0]), .req_ready_o(rdy[0]),
    .req_op_i(op_in[0]), .row_addr_i(addr_in[0]), .idx_i(idx_in[0]),
    .resp_valid_o(rsp_v[0]), .resp_hit_o(rsp_h[0]), .resp_idx_o(rsp_i[0])
`ifdef ROW_CAM_FREE_IDX_EN
    , .resp_free_vld_o(fv[0]), .resp_free_idx_o(fi[0])
`endif
  );

  row_addr_cam_multi #(.ADDR_W(AW), .N_ENTRY(10), .LANES(L)) u_b (
    .clk_i(clk), .rst_i(rst[1]), .req_valid_i(rv_in[1]), .req_ready_o(rdy[1]),
    .req_op_i(op_in[1]), .row_addr_i(addr_in[1]), .idx_i(idx_in[1]),
    .resp_valid_o(rsp_v[1]), .resp_hit_o(rsp_h[1]), .resp_idx_o(rsp_i[1])
`ifdef ROW_CAM_FREE_IDX_EN
    , .resp_free_vld_o(fv[1]), .resp_free_idx_o(fi[1])
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural reference: a plain table per instance.
  bit            mval [2][16];
  logic [AW-1:0] mdat [2][16];
  int            nent [2] = '{16, 10};

  task automatic model_op(input int d, input logic [1:0] op, input logic [AW-1:0] a,
                          input int idx, output bit e_hit, output int e_idx,
                          output int e_lat, output bit e_fv, output int e_fi);
    int nch;
    nch = (nent[d] + L - 1) / L;
    e_hit = 0; e_idx = 0; e_lat = 1; e_fv = 0; e_fi = 0;
    case (op)
      OP_S: begin
        for (int i = 0; i < nent[d]; i++)
          if (!e_hit && mval[d][i] && mdat[d][i] == a) begin
            e_hit = 1; e_idx = i;
          end
        e_lat = e_hit ? (e_idx / L) + 2 : nch + 1;
        if (!e_hit)
          for (int i = nent[d] - 1; i >= 0; i--)
            if (!mval[d][i]) begin e_fv = 1; e_fi = i; end
      end
      OP_W: begin
        if (idx < nent[d]) begin mval[d][idx] = 1; mdat[d][idx] = a; end
        e_idx = idx;
      end
      OP_I: begin
        if (idx < nent[d]) mval[d][idx] = 0;
        e_idx = idx;
      end
      default: for (int i = 0; i < 16; i++) mval[d][i] = 0;
    endcase
  endtask

  logic          last_fv;
  logic [IW-1:0] last_fi;

  // Issue one request (ready assumed), follow it to its response and check.
  task automatic do_op(input int d, input logic [1:0] op, input logic [AW-1:0] a,
                       input int idx, input bit use_tbl, input bit t_hit,
                       input int t_idx, input int t_lat, input string tag);
    bit   m_hit, m_fv, got, side_ok;
    int   m_idx, m_lat, m_fi, lat;
    logic h;
    logic [IW-1:0] ri;
    model_op(d, op, a, idx, m_hit, m_idx, m_lat, m_fv, m_fi);
    chk({tag, "_ready_in"}, 32'(rdy[d]), 32'd1);
    rv_in[d] = 1'b1; op_in[d] = op; addr_in[d] = a; idx_in[d] = IW'(idx);
    @(posedge clk); #1;
    rv_in[d] = 1'b0; op_in[d] = 2'($urandom); addr_in[d] = AW'($urandom);
    idx_in[d] = IW'($urandom);
    lat = 1; got = 0; side_ok = 1; h = 1'bx; ri = 'x;
    last_fv = 1'b0; last_fi = '0;
    while (lat <= 40) begin
      if (rsp_v[d] === 1'b1) begin
        got = 1; h = rsp_h[d]; ri = rsp_i[d];
`ifdef ROW_CAM_FREE_IDX_EN
        last_fv = fv[d]; last_fi = fi[d];
`endif
        break;
      end
      if (rdy[d] !== 1'b0 || rsp_h[d] !== 1'b0 || rsp_i[d] !== '0) side_ok = 0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_resp_seen"}, 32'(got), 32'd1);
    chk({tag, "_busy_quiet"}, 32'(side_ok), 32'd1);
    chk({tag, "_hit"}, 32'(h), use_tbl ? 32'(t_hit) : 32'(m_hit));
    chk({tag, "_idx"}, 32'(ri), use_tbl ? 32'(t_idx % 16) : 32'(m_idx % 16));
    chk({tag, "_latency"}, 32'(lat), use_tbl ? 32'(t_lat) : 32'(m_lat));
    chk({tag, "_ready_resp"}, 32'(rdy[d]), 32'd1);
`ifdef ROW_CAM_FREE_IDX_EN
    chk({tag, "_free_vld"}, 32'(last_fv), 32'(m_fv));
    chk({tag, "_free_idx"}, 32'(last_fi), 32'(m_fi));
`endif
  endtask

  typedef struct {
    int         d;
    logic [1:0] op;
    logic [15:0] a;
    int         idx;
    bit         hit;
    int         eidx;
    int         lat;
  } vec_t;

  vec_t tbl[15];

  initial begin
    bit quiet;
    tbl[0]  = '{0, OP_S, 16'h0000, 0,  0, 0,  5};
    tbl[1]  = '{0, OP_W, 16'h1234, 9,  0, 9,  1};
    tbl[2]  = '{0, OP_S, 16'h1234, 0,  1, 9,  4};
    tbl[3]  = '{0, OP_W, 16'hABCD, 3,  0, 3,  1};
    tbl[4]  = '{0, OP_W, 16'hABCD, 9,  0, 9,  1};
    tbl[5]  = '{0, OP_S, 16'hABCD, 0,  1, 3,  2};
    tbl[6]  = '{0, OP_I, 16'h0000, 3,  0, 3,  1};
    tbl[7]  = '{0, OP_S, 16'hABCD, 0,  1, 9,  4};
    tbl[8]  = '{0, OP_C, 16'h0000, 5,  0, 0,  1};
    tbl[9]  = '{0, OP_S, 16'hABCD, 0,  0, 0,  5};
    tbl[10] = '{1, OP_W, 16'h0055, 9,  0, 9,  1};
    tbl[11] = '{1, OP_S, 16'h0055, 0,  1, 9,  4};
    tbl[12] = '{1, OP_W, 16'h0077, 12, 0, 12, 1};
    tbl[13] = '{1, OP_S, 16'h0077, 0,  0, 0,  4};
    tbl[14] = '{1, OP_S, 16'h0000, 0,  0, 0,  4};

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; rv_in[d] = 1'b0; op_in[d] = '0; addr_in[d] = '0; idx_in[d] = '0;
      for (int i = 0; i < 16; i++) begin mval[d][i] = 0; mdat[d][i] = '0; end
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_ready_%0d", d), 32'(rdy[d]),   32'd1);
      chk($sformatf("reset_rvalid_%0d", d), 32'(rsp_v[d]), 32'd0);
      chk($sformatf("reset_hit_%0d", d),   32'(rsp_h[d]), 32'd0);
      chk($sformatf("reset_idx_%0d", d),   32'(rsp_i[d]), 32'd0);
    end

    for (int k = 0; k < 15; k++)
      do_op(tbl[k].d, tbl[k].op, tbl[k].a, tbl[k].idx, 1'b1,
            tbl[k].hit, tbl[k].eidx, tbl[k].lat, $sformatf("vec%0d", k));

    // Reset in cycle 2 of a search: no response, ready next cycle, table empty.
    do_op(0, OP_W, 16'hBEEF, 12, 1'b0, 0, 0, 0, "rstseq_wr");
    rv_in[0] = 1'b1; op_in[0] = OP_S; addr_in[0] = 16'hBEEF; idx_in[0] = '0;
    @(posedge clk); #1;
    rv_in[0] = 1'b0;
    @(posedge clk); #1;
    rst[0] = 1'b1;
    chk("rstseq_no_resp_c2", 32'(rsp_v[0]), 32'd0);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    chk("rstseq_ready_after", 32'(rdy[0]), 32'd1);
    quiet = 1;
    for (int c = 0; c < 6; c++) begin
      if (rsp_v[0] !== 1'b0) quiet = 0;
      @(posedge clk); #1;
    end
    chk("rstseq_no_pulse", 32'(quiet), 32'd1);
    for (int i = 0; i < 16; i++) mval[0][i] = 0;
    do_op(0, OP_S, 16'hBEEF, 0, 1'b1, 0, 0, 5, "rstseq_search");

`ifdef ROW_CAM_FREE_IDX_EN
    do_op(0, OP_C, 16'h0, 0, 1'b0, 0, 0, 0, "free_clr");
    for (int i = 0; i < 16; i++)
      if (i != 3) do_op(0, OP_W, 16'h0100 + 16'(i), i, 1'b0, 0, 0, 0, "free_fill");
    do_op(0, OP_S, 16'hFFFF, 0, 1'b1, 0, 0, 5, "free_s1");
    chk("free_hole_vld", 32'(last_fv), 32'd1);
    chk("free_hole_idx", 32'(last_fi), 32'd3);
    do_op(0, OP_W, 16'h0103, 3, 1'b0, 0, 0, 0, "free_fill3");
    do_op(0, OP_S, 16'hFFFF, 0, 1'b1, 0, 0, 5, "free_s2");
    chk("free_full_vld", 32'(last_fv), 32'd0);
`endif

    // Randomised traffic against the reference model.
    for (int n = 0; n < 250; n++) begin
      int d, r, idx;
      logic [1:0] op;
      logic [AW-1:0] a;
      d = $urandom_range(0, 1);
      r = $urandom_range(0, 19);
      if (r < 8)       op = OP_S;
      else if (r < 15) op = OP_W;
      else if (r < 18) op = OP_I;
      else             op = ($urandom_range(0, 2) == 0) ? OP_C : OP_S;
      a   = ($urandom_range(0, 4) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      idx = $urandom_range(0, 15);
      do_op(d, op, a, idx, 1'b0, 0, 0, 0, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
